// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
//   Shared definitions for the memory bus arbiter: FSM state encoding,
//   default parameter values and bus field widths.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  localparam int unsigned DEFAULT_NMASTERS = 3;
  localparam int unsigned DEFAULT_TIMEOUT  = 255;

  localparam int unsigned WDOG_W = 16;
  localparam int unsigned ADR_W  = 32;
  localparam int unsigned DAT_W  = 32;
  localparam int unsigned SEL_W  = 4;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// bus_arbiter_rr_pick
//   Combinational round-robin priority select. Scans the request vector
//   starting at (last_i + 1) mod N and wrapping; the first set bit wins.
// Ports:
//   req_i    [N-1:0]     request vector
//   last_i   [IDXW-1:0]  index granted last time (lowest priority now)
//   idx_o    [IDXW-1:0]  winning index (0 when no request)
//   valid_o              at least one request present
module bus_arbiter_rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N    = DEFAULT_NMASTERS,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] last_i,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  logic [IDXW-1:0] cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    // i runs 1..N so that last_i itself is checked last.
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IDXW'((int'(last_i) + int'(i)) % int'(N));
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Round-robin arbiter sharing one 32-bit memory bus between NMASTERS
//   masters. Ownership lasts a whole bus cycle (while the owner holds cyc).
//   A watchdog aborts an owner cycle that never acks and flags m_err_o.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no owner; round-robin pick among current requests
//   GRANT  | owner's request muxed to slave, ack/data routed back
//   ABORT  | watchdog fired; slave cycle dropped, wait for owner release
//
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   m_cyc_i/m_we_i          per-master cycle request / write enable
//   m_adr_i/m_dat_i/m_sel_i per-master address, write data, byte enables
//   m_ack_o/m_err_o         per-master ack / timeout error (owner only)
//   m_dat_o                 read data to masters
//   s_*_o                   owner's request to the slave
//   s_ack_i/s_dat_i         slave response
//   owner_o                 current / last granted master
//   busy_o                  high in GRANT
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter  int unsigned NMASTERS = DEFAULT_NMASTERS,
  parameter  int unsigned TIMEOUT  = DEFAULT_TIMEOUT,
  localparam int unsigned IDXW     = $clog2(NMASTERS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NMASTERS-1:0]   m_cyc_i,
  input  logic [NMASTERS-1:0]   m_we_i,
  input  logic [NMASTERS*32-1:0] m_adr_i,
  input  logic [NMASTERS*32-1:0] m_dat_i,
  input  logic [NMASTERS*4-1:0] m_sel_i,
  output logic [NMASTERS-1:0]   m_ack_o,
  output logic [NMASTERS-1:0]   m_err_o,
  output logic [31:0]           m_dat_o,
  output logic                  s_cyc_o,
  output logic                  s_we_o,
  output logic [31:0]           s_adr_o,
  output logic [31:0]           s_dat_o,
  output logic [3:0]            s_sel_o,
  input  logic                  s_ack_i,
  input  logic [31:0]           s_dat_i,
  output logic [IDXW-1:0]       owner_o,
  output logic                  busy_o
);

  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [IDXW-1:0]   last_q, last_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  logic              own_cyc;
  logic              own_we;
  logic [ADR_W-1:0]  own_adr;
  logic [DAT_W-1:0]  own_dat;
  logic [SEL_W-1:0]  own_sel;
  logic [IDXW-1:0]   pick_idx;
  logic              pick_valid;
  logic              timeout_hit;

  bus_arbiter_rr_pick #(
    .N    (NMASTERS),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req_i   (m_cyc_i),
    .last_i  (last_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Owner's request fields, selected from the flattened per-master buses.
  always_comb begin
    own_cyc = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    for (int k = 0; k < int'(NMASTERS); k++) begin
      if (owner_q == IDXW'(k)) begin
        own_cyc = m_cyc_i[k];
        own_we  = m_we_i[k];
        own_adr = m_adr_i[k*32 +: 32];
        own_dat = m_dat_i[k*32 +: 32];
        own_sel = m_sel_i[k*4 +: 4];
      end
    end
  end

  // Fires in the TIMEOUT-th consecutive unacked cycle; an ack or a release
  // in that same cycle takes precedence.
  assign timeout_hit = (state_q == ST_GRANT) && own_cyc && !s_ack_i &&
                       (wdog_q == WDOG_LIMIT);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IDXW'(NMASTERS - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
          wdog_d  = '0;
        end
      end
      ST_GRANT: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end else if (s_ack_i) begin
          wdog_d = '0;
        end else if (timeout_hit) begin
          state_d = ST_ABORT;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      ST_ABORT: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    busy_o  = 1'b0;
    if (state_q == ST_GRANT) begin
      busy_o  = 1'b1;
      s_cyc_o = own_cyc;
      s_we_o  = own_we;
      s_adr_o = own_adr;
      s_dat_o = own_dat;
      s_sel_o = own_sel;
      m_dat_o = s_dat_i;
      for (int k = 0; k < int'(NMASTERS); k++) begin
        if (owner_q == IDXW'(k)) begin
          m_ack_o[k] = s_ack_i && own_cyc;
          m_err_o[k] = timeout_hit;
        end
      end
    end
  end

  assign owner_o = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int NM = 3;
  localparam int TO = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [NM-1:0]   m_cyc_i, m_we_i;
  logic [NM*32-1:0] m_adr_i, m_dat_i;
  logic [NM*4-1:0] m_sel_i;
  logic [NM-1:0]   m_ack_o, m_err_o;
  logic [31:0]     m_dat_o;
  logic            s_cyc_o, s_we_o;
  logic [31:0]     s_adr_o, s_dat_o;
  logic [3:0]      s_sel_o;
  logic            s_ack_i;
  logic [31:0]     s_dat_i;
  logic [1:0]      owner_o;
  logic            busy_o;

  bus_arbiter #(.NMASTERS(NM), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_cyc_i(m_cyc_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
    .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .owner_o(owner_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  int          gnt_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=<nothing queued>", tag, obs);
    end else begin
      chk(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic clr_inputs();
    m_cyc_i = '0; m_we_i = '0; m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_ack_i = 1'b0; s_dat_i = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_scyc"},  s_cyc_o, 0);
    chk({tag, "_swe"},   s_we_o, 0);
    chk({tag, "_sadr"},  s_adr_o, 0);
    chk({tag, "_sdat"},  s_dat_o, 0);
    chk({tag, "_ssel"},  s_sel_o, 0);
    chk({tag, "_mack"},  m_ack_o, 0);
    chk({tag, "_merr"},  m_err_o, 0);
    chk({tag, "_mdat"},  m_dat_o, 0);
    chk({tag, "_owner"}, owner_o, 0);
    chk({tag, "_busy"},  busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL tb_time_limit simulation did not finish in time");
    $fatal(1, "time limit");
  end

  initial begin
    int errs;
    int last_ack;
    int grants;
    int idx;
    logic [NM-1:0] drop_mask;

    // ---------------- reset state, with busy-looking inputs
    clr_inputs();
    rst_ni  = 1'b0;
    m_cyc_i = '1; m_we_i = '1; m_sel_i = '1;
    m_adr_i = {32'h2222_2222, 32'h1111_1111, 32'h0000_0004};
    m_dat_i = {3{32'h5A5A_5A5A}};
    s_ack_i = 1'b1; s_dat_i = 32'hA5A5_A5A5;
    nxt(); nxt(); smp();
    chk_all_zero("rst");
    nxt(); rst_ni = 1'b1; clr_inputs(); smp();
    chk("idle_busy", busy_o, 0);

    // ---------------- T1: master 0 read, two wait states
    nxt();
    m_cyc_i = 3'b001; m_adr_i[31:0] = 32'h0000_0040; m_sel_i[3:0] = 4'hF;
    exp_q.push_back(32'hDEAD_BEEF);
    smp();
    chk("t1_req_scyc", s_cyc_o, 0);
    nxt(); smp();
    chk("t1_gnt_scyc", s_cyc_o, 1);
    chk("t1_gnt_sadr", s_adr_o, 32'h40);
    chk("t1_gnt_ssel", s_sel_o, 4'hF);
    chk("t1_gnt_owner", owner_o, 0);
    chk("t1_gnt_busy", busy_o, 1);
    chk("t1_wait1_ack", m_ack_o, 0);
    nxt(); smp();
    chk("t1_wait2_ack", m_ack_o, 0);
    nxt(); s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF; smp();
    chk("t1_ack", m_ack_o, 3'b001);
    if (m_ack_o[0]) pop_chk("t1_rdata", m_dat_o);
    nxt(); s_ack_i = 1'b0; s_dat_i = '0; m_cyc_i = '0; smp();
    chk("t1_rel_scyc", s_cyc_o, 0);
    chk("t1_rel_ack", m_ack_o, 0);
    nxt(); smp();
    chk("t1_idle_busy", busy_o, 0);

    // ---------------- T2: three masters, round robin from reset
    nxt(); rst_ni = 1'b0;
    nxt(); rst_ni = 1'b1;
    gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(2); gnt_q.push_back(0);
    s_ack_i = 1'b1;
    drop_mask = '0;
    last_ack = -1;
    grants = 0;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      nxt();
      m_cyc_i = ~drop_mask;
      smp();
      if (m_ack_o != '0) begin
        chk("t2_onehot", $countones(m_ack_o), 1);
        idx = 0;
        for (int k = 0; k < NM; k++) if (m_ack_o[k]) idx = k;
        if (gnt_q.size() == 0) begin
          n_tests++; n_fail++;
          $error("FAIL t2_order observed=%0d expected=<no more grants>", idx);
        end else begin
          chk("t2_order", idx, gnt_q.pop_front());
        end
        if (last_ack >= 0) chk("t2_gap", c - last_ack, 3);
        last_ack = c;
        grants++;
        drop_mask = m_ack_o;
      end else begin
        drop_mask = '0;
      end
    end
    chk("t2_grants", grants, 4);
    nxt(); m_cyc_i = '0; s_ack_i = 1'b0;
    nxt(); nxt();

    // ---------------- T3: master 1 burst of 4 writes, master 2 waits
    nxt();
    m_cyc_i = 3'b010; m_we_i = 3'b010; m_sel_i = 12'hFFF;
    m_adr_i[63:32] = 32'h1000; m_dat_i[63:32] = 32'hC0DE_0000;
    m_adr_i[95:64] = 32'h2000;
    smp();
    for (int b = 0; b < 4; b++) begin
      nxt();
      m_cyc_i = 3'b110;
      m_adr_i[63:32] = 32'h1000 + 32'(4 * b);
      m_dat_i[63:32] = 32'hC0DE_0000 + 32'(b);
      s_ack_i = 1'b0;
      smp();
      chk("t3_wait_owner", owner_o, 1);
      chk("t3_wait_ack", m_ack_o, 0);
      nxt();
      s_ack_i = 1'b1;
      exp_q.push_back(32'h1000 + 32'(4 * b));
      smp();
      chk("t3_ack", m_ack_o, 3'b010);
      if (m_ack_o[1]) pop_chk("t3_addr", s_adr_o);
      chk("t3_we", s_we_o, 1);
      chk("t3_wdat", s_dat_o, 32'hC0DE_0000 + 32'(b));
    end
    nxt(); s_ack_i = 1'b0; m_cyc_i = 3'b100; smp();
    chk("t3_rel_scyc", s_cyc_o, 0);
    chk("t3_rel_owner", owner_o, 1);
    nxt(); smp();
    chk("t3_dead_scyc", s_cyc_o, 0);
    chk("t3_dead_busy", busy_o, 0);
    nxt(); smp();
    chk("t3_m2_owner", owner_o, 2);
    chk("t3_m2_scyc", s_cyc_o, 1);
    chk("t3_m2_sadr", s_adr_o, 32'h2000);
    nxt(); s_ack_i = 1'b1; smp();
    chk("t3_m2_ack", m_ack_o, 3'b100);
    nxt(); s_ack_i = 1'b0; m_cyc_i = '0;
    nxt();

    // ---------------- T4: watchdog abort on master 0
    nxt(); m_cyc_i = 3'b001; m_we_i = '0; m_adr_i[31:0] = 32'h3000; smp();
    errs = 0;
    for (int g = 1; g <= TO; g++) begin
      nxt(); smp();
      chk("t4_scyc", s_cyc_o, 1);
      chk("t4_err", m_err_o, (g == TO) ? 3'b001 : 3'b000);
      errs += $countones(m_err_o);
    end
    for (int g = 0; g < 3; g++) begin
      nxt(); smp();
      chk("t4_abort_scyc", s_cyc_o, 0);
      chk("t4_abort_err", m_err_o, 0);
      chk("t4_abort_busy", busy_o, 0);
      errs += $countones(m_err_o);
    end
    chk("t4_err_count", errs, 1);
    nxt(); m_cyc_i = '0; smp();
    nxt(); m_cyc_i = 3'b100; smp();
    chk("t4_idle_scyc", s_cyc_o, 0);
    nxt(); smp();
    chk("t4_regrant_owner", owner_o, 2);
    chk("t4_regrant_scyc", s_cyc_o, 1);
    nxt(); m_cyc_i = '0;
    nxt();

    // ---------------- T5: ack on the timeout cycle wins
    nxt(); m_cyc_i = 3'b010; smp();
    for (int g = 1; g < TO; g++) begin
      nxt(); smp();
      chk("t5_pre_err", m_err_o, 0);
    end
    nxt(); s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    smp();
    chk("t5_tc_err", m_err_o, 0);
    chk("t5_tc_ack", m_ack_o, 3'b010);
    if (m_ack_o[1]) pop_chk("t5_rdata", m_dat_o);
    for (int g = 1; g < TO; g++) begin
      nxt(); s_ack_i = 1'b0; s_dat_i = '0; smp();
      chk("t5_post_err", m_err_o, 0);
      chk("t5_post_scyc", s_cyc_o, 1);
    end
    nxt(); m_cyc_i = '0; smp();
    chk("t5_rel_err", m_err_o, 0);
    nxt();

    // ---------------- T5b: owner drops cyc on the timeout cycle
    nxt(); m_cyc_i = 3'b100; smp();
    for (int g = 1; g < TO; g++) begin
      nxt(); smp();
    end
    nxt(); m_cyc_i = '0; smp();
    chk("t5b_drop_err", m_err_o, 0);
    chk("t5b_drop_scyc", s_cyc_o, 0);
    nxt(); smp();
    chk("t5b_idle_busy", busy_o, 0);

    // ---------------- T6: reset in the middle of a grant
    nxt(); m_cyc_i = 3'b010; m_adr_i[63:32] = 32'h4444; smp();
    nxt(); smp();
    chk("t6_owner", owner_o, 1);
    chk("t6_busy", busy_o, 1);
    nxt(); rst_ni = 1'b0; m_cyc_i = 3'b111; s_ack_i = 1'b1; s_dat_i = 32'hFEED_FACE; smp();
    chk("t6_pre_rst_ack", m_ack_o, 3'b010);
    nxt(); rst_ni = 1'b1; smp();
    chk_all_zero("t6_post_rst");
    nxt(); smp();
    chk("t6_first_owner", owner_o, 0);
    chk("t6_first_scyc", s_cyc_o, 1);
    chk("t6_first_ack", m_ack_o, 3'b001);
    nxt(); clr_inputs();
    nxt();

    chk("sb_data_empty", exp_q.size(), 0);
    chk("sb_grant_empty", gnt_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single 32-bit memory bus between NMASTERS bus masters (bexkat1 CPU, DMA, video fetch). It grants ownership for a whole bus cycle (while the owner holds cyc), muxes the owner's request onto the slave bus, and routes ack and read data back only to the owner. A watchdog aborts any cycle that never acks and returns a bus error to the owner.

## Interface
- NMASTERS, 3: number of requesters, 2..8.
- TIMEOUT, 255: max cycles without ack before abort, 1..65535.
- clk_i  in  1  system clock.
- rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i.
- m_cyc_i  in  NMASTERS  per-master cycle request.
- m_we_i  in  NMASTERS  per-master write enable.
- m_adr_i  in  NMASTERS*32  per-master address, master k at [32k+31:32k].
- m_dat_i  in  NMASTERS*32  per-master write data.
- m_sel_i  in  NMASTERS*4  per-master byte enables.
- m_ack_o  out  NMASTERS  per-master ack; only owner's bit can be 1.
- m_err_o  out  NMASTERS  per-master timeout error pulse.
- m_dat_o  out  32  read data, broadcast to all masters.
- s_cyc_o, s_we_o  out  1  slave cycle / write.
- s_adr_o  out  32; s_dat_o out 32; s_sel_o out 4: owner's request.
- s_ack_i  in  1; s_dat_i  in  32: slave response.
- owner_o  out  clog2(NMASTERS)  current/last grant index.
- busy_o  out  1  high in GRANT.

## Operation
- States: IDLE, GRANT, ABORT.
- IDLE: if any m_cyc_i set, pick first requester starting at (last+1) mod NMASTERS, wrapping; register owner, go GRANT. No request: stay.
- GRANT: s_cyc_o = m_cyc_i[owner]; s_we/adr/dat/sel = owner's fields; m_ack_o[owner] = s_ack_i; m_dat_o = s_dat_i. Owner may run multiple acked beats while cyc stays high.
- Owner drops m_cyc_i: go IDLE; last := owner.
- Watchdog: 16-bit counter, cleared on entry to GRANT and on each s_ack_i; increments each GRANT cycle without ack. On reaching TIMEOUT: m_err_o[owner] pulses one cycle, go ABORT.
- ABORT: s_cyc_o = 0, no acks; wait until owner drops cyc, then IDLE, last := owner.
- Non-owners: m_ack_o, m_err_o held 0; requests wait.
- Reset (any state, mid-cycle included): state IDLE, owner_o 0, last = NMASTERS-1 (so master 0 wins first), counter 0; all outputs 0 (s_cyc_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, m_ack_o, m_err_o, busy_o, m_dat_o).

## Timing
- Grant latency: request in cycle n (state IDLE) -> s_cyc_o high in cycle n+1.
- Slave outputs and m_ack_o are combinational from registered owner; ack passes through in zero cycles.
- Release: owner drops cyc in cycle n -> IDLE in n+1 -> next grant visible n+2. One dead cycle between owners, always.
- ack and timeout in same cycle: ack wins, counter clears, no error.
- Owner dropping cyc in the cycle TIMEOUT is reached: go IDLE, no error.
- Non-owner requests in GRANT are not latched; must be held until granted.

## Structure
- Shared package: state encoding constants (IDLE, GRANT, ABORT), defaults for TIMEOUT.
- One sub-module natural: rr_pick (combinational round-robin priority from request vector and last index, returns index and valid).

## Test plan
- Reset then master 0 read, slave acks after 2 waits, data 0xDEADBEEF -> s_cyc_o one cycle after request, m_ack_o=3'b001 once, m_dat_o=0xDEADBEEF.
- Masters 0,1,2 request together continuously, one beat each -> grant order 0,1,2,0 with one idle cycle between grants.
- Master 1 holds cyc for 4 acked writes to 0x1000..0x100C while master 2 requests -> master 2 not granted until master 1 releases.
- TIMEOUT=8, slave never acks -> m_err_o[owner] pulses exactly once at 8th unacked cycle, s_cyc_o drops, IDLE after owner drops cyc.
- Ack arriving on the TIMEOUT cycle -> no error, transfer completes.
- rst_ni low mid-GRANT -> next cycle all outputs 0, next grant goes to master 0.
